// File: rtl/line_mem_pkg.sv
// rtl/line_mem_pkg.sv - shared types, line geometry and range check for the line memory requester
package line_mem_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCESS    = 2'd1,
    RESP      = 2'd2,
    PF_ACCESS = 2'd3
  } state_e;

  localparam int         LINE_BYTES = 16;
  localparam int         LINE_W     = 128;
  localparam int         OFFSET_W   = $clog2(LINE_BYTES);
  localparam logic [1:0] MTYPE_LINE = 2'b11;

  // Bits [addr_w-2 : mem_aw] must be zero; the top bit is an uncached alias and is not checked.
  function automatic logic in_range(input logic [63:0] addr, input int addr_w, input int mem_aw);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i >= mem_aw && i <= addr_w - 2 && addr[i]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/line_prefetch_buf.sv
// rtl/line_prefetch_buf.sv - one-entry next-line buffer {valid,tag,data}; built only with NEXT_LINE_PREFETCH_EN
`ifdef NEXT_LINE_PREFETCH_EN
module line_prefetch_buf
  import line_mem_pkg::*;
#(
  parameter int TAG_W = 27
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fill,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_data,
  input  logic [TAG_W-1:0]  lookup_tag,
  input  logic              inval,
  output logic              hit,
  output logic [LINE_W-1:0] hit_data
);

  logic              valid;
  logic [TAG_W-1:0]  tag;
  logic [LINE_W-1:0] data;

  assign hit      = valid && (tag == lookup_tag);
  assign hit_data = data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      data  <= fill_data;
    end else if (inval && hit) begin
      valid <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/line_mem_requester.sv
// rtl/line_mem_requester.sv - one-at-a-time cache line read/write initiator for the 128-bit line RAM
// Optional next-line prefetch buffer enabled by defining NEXT_LINE_PREFETCH_EN.
module line_mem_requester
  import line_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 16,
  parameter int MEM_BYTES  = 512,
  parameter int MEM_LAT    = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [LINE_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_din,
  output logic              mem_we,
  output logic [1:0]        mem_mtype,
  input  logic [LINE_W-1:0] mem_dout
);

  localparam int                MEM_AW     = $clog2(MEM_BYTES);
  localparam int                LINE_OFF_W = $clog2(LINE_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_BYTES - 1);
  localparam logic [3:0]        LAT        = 4'(MEM_LAT);

  state_e            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic              err_q;
  logic [LINE_W-1:0] wdata_q;

  logic              req_fire;
  logic              resp_fire;
  logic              last_cycle;
  logic [ADDR_W-1:0] req_line;
  logic [ADDR_W-1:0] next_line;
  logic              req_err;
  logic              next_ok;

  // Gate with reset so the requester never advertises readiness while held in reset.
  assign req_ready  = (state == IDLE) && !reset;
  assign req_fire   = req_valid && req_ready;
  assign resp_valid = (state == RESP);
  assign resp_fire  = resp_valid && resp_ready;
  assign last_cycle = (cnt == 4'd0);
  assign req_line   = req_addr & ALIGN_MASK;
  assign req_err    = !in_range(64'(req_line), ADDR_W, MEM_AW);
  assign next_line  = addr_q + ADDR_W'(LINE_BYTES);
  assign next_ok    = !wen_q && !err_q && in_range(64'(next_line), ADDR_W, MEM_AW);

  assign mem_mtype = MTYPE_LINE;
  assign mem_addr  = (state == ACCESS || state == PF_ACCESS) ? addr_q : '0;
  assign mem_din   = (state == ACCESS) ? wdata_q : '0;
  // cnt still holds its load value only in the first ACCESS cycle
  assign mem_we    = (state == ACCESS) && wen_q && !err_q && (cnt == LAT);

  logic              pf_hit;
  logic [LINE_W-1:0] pf_data;

`ifdef NEXT_LINE_PREFETCH_EN
  localparam bit PF_EN = 1'b1;

  logic pf_fill;
  logic pf_inval;

  assign pf_fill  = (state == PF_ACCESS) && last_cycle;
  assign pf_inval = req_fire && req_wen;

  // Tags drop the alias bit so an aliased address still matches its RAM line.
  line_prefetch_buf #(
    .TAG_W(ADDR_W - 1 - LINE_OFF_W)
  ) u_prefetch_buf (
    .clock      (clock),
    .reset      (reset),
    .fill       (pf_fill),
    .fill_tag   (addr_q[ADDR_W-2:LINE_OFF_W]),
    .fill_data  (mem_dout),
    .lookup_tag (req_line[ADDR_W-2:LINE_OFF_W]),
    .inval      (pf_inval),
    .hit        (pf_hit),
    .hit_data   (pf_data)
  );
`else
  localparam bit PF_EN = 1'b0;

  assign pf_hit  = 1'b0;
  assign pf_data = '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      err_q      <= 1'b0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            addr_q  <= req_line;
            wen_q   <= req_wen;
            wdata_q <= req_wdata;
            err_q   <= req_err;
            cnt     <= LAT;
            if (!req_wen && pf_hit) begin
              state      <= RESP;
              resp_rdata <= pf_data;
              resp_err   <= 1'b0;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (last_cycle) begin
            state      <= RESP;
            resp_rdata <= (wen_q || err_q) ? '0 : mem_dout;
            resp_err   <= err_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_fire) begin
            if (PF_EN && next_ok) begin
              state  <= PF_ACCESS;
              addr_q <= next_line;
              cnt    <= LAT;
            end else begin
              state <= IDLE;
            end
          end
        end
        PF_ACCESS: begin
          if (last_cycle) state <= IDLE;
          else            cnt   <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
